// File: rtl/decode_ctrl_stage_if.sv
// Upstream IF/ID handshake bundle for the decode stage.
// master: in_valid/instr/pc out, in_ready in; slave: the reverse.

interface decode_ctrl_stage_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     instr;
   logic [XLEN-1:0] pc;

   modport master (
      output in_valid,
      output instr,
      output pc,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  instr,
      input  pc,
      output in_ready
   );
endinterface

// File: rtl/decode_ctrl_stage.sv
// RV32I(+M) decode stage with a registered ID/EX control bundle
// and a mul/div busy sequencer that holds off upstream.
//
// Ports:
//   clk, rst       rising-edge clock, synchronous active-high reset
//   up (slave)     in_valid/in_ready/instr/pc from IF/ID
//   stall_ex       downstream hold; flush kills the bundle
//   out_valid      ID/EX bundle valid; out_pc/out_instr copies
//   ALUASrc..md_funct  registered control fields
//   illegal        registered instruction is illegal
//   illegal_count  saturating count of accepted illegal instrs

module decode_ctrl_stage #(
   parameter int XLEN     = 32,
   parameter int ENABLE_M = 1,
   parameter int MUL_LAT  = 3,
   parameter int DIV_LAT  = 8
) (
   input  logic            clk,
   input  logic            rst,
   decode_ctrl_stage_if.slave up,
   input  logic            stall_ex,
   input  logic            flush,
   output logic            out_valid,
   output logic [XLEN-1:0] out_pc,
   output logic [31:0]     out_instr,
   output logic            ALUASrc,
   output logic            ALUBSrc,
   output logic [3:0]      ALUOp,
   output logic [4:0]      BrOp,
   output logic            DMWr,
   output logic [2:0]      DMCtrl,
   output logic            RUWr,
   output logic [1:0]      RUDATAWrSrc,
   output logic [2:0]      ImmSrc_de,
   output logic            DMRd,
   output logic            md_op,
   output logic [2:0]      md_funct,
   output logic            illegal,
   output logic [15:0]     illegal_count
);

   typedef struct packed {
      logic       asrc;
      logic       bsrc;
      logic [3:0] aluop;
      logic [4:0] brop;
      logic       dmwr;
      logic [2:0] dmctrl;
      logic       ruwr;
      logic [1:0] wrsrc;
      logic [2:0] imm;
      logic       dmrd;
      logic       mdop;
      logic [2:0] mdf;
      logic       ill;
   } ctrl_t;

   typedef enum logic {
      IDLE,
      MD_BUSY
   } state_e;

   localparam bit EN_M = (ENABLE_M != 0);

   // Counter preload is LAT-1 so the busy window is LAT cycles.
   localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
   localparam logic [3:0] DIV_CNT = 4'(DIV_LAT - 1);

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_IALU  = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MD   = 7'b0000001;

   state_e          state_q, state_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            valid_q, valid_d;
   ctrl_t           ctrl_q, ctrl_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [31:0]     instr_q, instr_d;
   logic [15:0]     icnt_q, icnt_d;

   logic [6:0] op;
   logic [2:0] f3;
   logic [6:0] f7;
   logic       is_r, is_ialu, is_load, is_store;
   logic       is_br, is_jalr, is_jal, is_lui, is_auipc;
   logic       is_m;
   logic       ready;
   logic       xfer;
   ctrl_t      dec;
   logic       dec_ok;

   assign op = up.instr[6:0];
   assign f3 = up.instr[14:12];
   assign f7 = up.instr[31:25];

   assign is_r     = (op == OP_R);
   assign is_ialu  = (op == OP_IALU);
   assign is_load  = (op == OP_LOAD);
   assign is_store = (op == OP_STORE);
   assign is_br    = (op == OP_BR);
   assign is_jalr  = (op == OP_JALR);
   assign is_jal   = (op == OP_JAL);
   assign is_lui   = (op == OP_LUI);
   assign is_auipc = (op == OP_AUIPC);

   assign is_m = is_r && (f7 == F7_MD) && EN_M;

   // ------------------------------------------------------------
   // Combinational decode of the instruction on the upstream bus.
   // Full 7-bit opcode match also rejects instr[1:0] != 11.
   // ------------------------------------------------------------
   always_comb begin
      dec    = '0;
      dec_ok = 1'b0;
      unique case (1'b1)
         is_r: begin
            dec.ruwr = 1'b1;
            if (is_m) begin
               dec_ok    = 1'b1;
               dec.mdop  = 1'b1;
               dec.mdf   = f3;
               dec.wrsrc = 2'b11;
            end else begin
               dec_ok = (f7 == F7_BASE) ||
                        ((f7 == F7_ALT) &&
                         ((f3 == 3'b000) || (f3 == 3'b101)));
               dec.aluop = {f7[5], f3};
            end
         end
         is_ialu: begin
            dec.ruwr = 1'b1;
            unique case (f3)
               3'b001: begin
                  dec_ok    = (f7 == F7_BASE);
                  dec.aluop = {f7[5], f3};
               end
               3'b101: begin
                  dec_ok    = (f7 == F7_BASE) ||
                              (f7 == F7_ALT);
                  dec.aluop = {f7[5], f3};
               end
               default: begin
                  // imm[10] sits at bit 30; ignore it here.
                  dec_ok    = 1'b1;
                  dec.aluop = {1'b0, f3};
               end
            endcase
         end
         is_load: begin
            dec_ok     = (f3 != 3'b011) &&
                         (f3 != 3'b110) &&
                         (f3 != 3'b111);
            dec.dmctrl = f3;
            dec.dmrd   = 1'b1;
            dec.ruwr   = 1'b1;
            dec.wrsrc  = 2'b01;
         end
         is_store: begin
            dec_ok   = (f3 <= 3'b010);
            dec.dmwr = 1'b1;
            dec.imm  = 3'b001;
         end
         is_br: begin
            dec_ok   = (f3 != 3'b010) && (f3 != 3'b011);
            dec.brop = {2'b01, f3};
            dec.imm  = 3'b101;
         end
         is_jalr: begin
            dec_ok    = (f3 == 3'b000);
            dec.brop  = 5'b10000;
            dec.ruwr  = 1'b1;
            dec.wrsrc = 2'b10;
         end
         is_jal: begin
            dec_ok    = 1'b1;
            dec.brop  = 5'b10000;
            dec.ruwr  = 1'b1;
            dec.wrsrc = 2'b10;
            dec.imm   = 3'b110;
         end
         is_lui: begin
            dec_ok    = 1'b1;
            dec.aluop = 4'b0111;
            dec.ruwr  = 1'b1;
            dec.imm   = 3'b010;
         end
         is_auipc: begin
            dec_ok   = 1'b1;
            dec.asrc = 1'b1;
            dec.ruwr = 1'b1;
            dec.imm  = 3'b010;
         end
         default: dec_ok = 1'b0;
      endcase
      // Illegal instructions carry no side-effecting control.
      if (!dec_ok) begin
         dec     = '0;
         dec.ill = 1'b1;
      end
   end

   // ------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------
   assign ready = !rst && !stall_ex && !flush &&
                  (state_q == IDLE);
   assign xfer  = up.in_valid && ready;

   assign up.in_ready = ready;

   // ------------------------------------------------------------
   // Mul/div sequencer: next state
   // ------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (xfer && dec.mdop) begin
               state_d = MD_BUSY;
               cnt_d   = f3[2] ? DIV_CNT : MUL_CNT;
            end
         end
         MD_BUSY: begin
            // Counts down regardless of stall_ex.
            if (flush) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == 4'd0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------
   // ID/EX bundle: flush > stall > transfer > bubble.
   // A bubble also clears the controls so side-effect
   // fields read zero whenever out_valid is low.
   // ------------------------------------------------------------
   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      icnt_d  = icnt_q;
      if (flush) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end else if (stall_ex) begin
         valid_d = valid_q;
      end else if (xfer) begin
         valid_d = 1'b1;
         ctrl_d  = dec;
         pc_d    = up.pc;
         instr_d = up.instr;
         if (dec.ill && (icnt_q != 16'hFFFF)) begin
            icnt_d = icnt_q + 16'd1;
         end
      end else begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         pc_q    <= '0;
         instr_q <= '0;
         icnt_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         icnt_q  <= icnt_d;
      end
   end

   assign out_valid     = valid_q;
   assign out_pc        = pc_q;
   assign out_instr     = instr_q;
   assign ALUASrc       = ctrl_q.asrc;
   assign ALUBSrc       = ctrl_q.bsrc;
   assign ALUOp         = ctrl_q.aluop;
   assign BrOp          = ctrl_q.brop;
   assign DMWr          = ctrl_q.dmwr;
   assign DMCtrl        = ctrl_q.dmctrl;
   assign RUWr          = ctrl_q.ruwr;
   assign RUDATAWrSrc   = ctrl_q.wrsrc;
   assign ImmSrc_de     = ctrl_q.imm;
   assign DMRd          = ctrl_q.dmrd;
   assign md_op         = ctrl_q.mdop;
   assign md_funct      = ctrl_q.mdf;
   assign illegal       = ctrl_q.ill;
   assign illegal_count = icnt_q;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Bench for decode_ctrl_stage: two DUTs (ENABLE_M=0 and =1)
// share one stimulus stream and are compared to a model.

module tb_decode_ctrl_stage;

   typedef struct packed {
      logic       asrc;
      logic       bsrc;
      logic [3:0] aluop;
      logic [4:0] brop;
      logic       dmwr;
      logic [2:0] dmctrl;
      logic       ruwr;
      logic [1:0] wrsrc;
      logic [2:0] imm;
      logic       dmrd;
      logic       mdop;
      logic [2:0] mdf;
      logic       ill;
   } ctrl_t;

   localparam int LAT_MUL = 3;
   localparam int LAT_DIV = 8;

   localparam logic [31:0] I_ADD = 32'h003100B3;
   localparam logic [31:0] I_LW  = 32'h00012083;
   localparam logic [31:0] I_SW  = 32'h00112023;
   localparam logic [31:0] I_MUL = 32'h023100B3;
   localparam logic [31:0] I_DIV = 32'h023140B3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, in_valid, stall_ex, flush;
   logic [31:0] instr, pc;

   logic        ir_w     [2];
   logic        ov_w     [2];
   logic [31:0] opc_w    [2];
   logic [31:0] oin_w    [2];
   logic        asrc_w   [2];
   logic        bsrc_w   [2];
   logic [3:0]  aluop_w  [2];
   logic [4:0]  brop_w   [2];
   logic        dmwr_w   [2];
   logic [2:0]  dmctrl_w [2];
   logic        ruwr_w   [2];
   logic [1:0]  wrsrc_w  [2];
   logic [2:0]  imm_w    [2];
   logic        dmrd_w   [2];
   logic        mdop_w   [2];
   logic [2:0]  mdf_w    [2];
   logic        ill_w    [2];
   logic [15:0] icnt_w   [2];

   decode_ctrl_stage_if #(.XLEN(32)) if0 ();
   decode_ctrl_stage_if #(.XLEN(32)) if1 ();

   assign if0.in_valid = in_valid;
   assign if0.instr    = instr;
   assign if0.pc       = pc;
   assign if1.in_valid = in_valid;
   assign if1.instr    = instr;
   assign if1.pc       = pc;
   assign ir_w[0]      = if0.in_ready;
   assign ir_w[1]      = if1.in_ready;

   decode_ctrl_stage #(
      .XLEN(32), .ENABLE_M(0),
      .MUL_LAT(LAT_MUL), .DIV_LAT(LAT_DIV)
   ) u0 (
      .clk(clk), .rst(rst), .up(if0.slave),
      .stall_ex(stall_ex), .flush(flush),
      .out_valid(ov_w[0]), .out_pc(opc_w[0]),
      .out_instr(oin_w[0]), .ALUASrc(asrc_w[0]),
      .ALUBSrc(bsrc_w[0]), .ALUOp(aluop_w[0]),
      .BrOp(brop_w[0]), .DMWr(dmwr_w[0]),
      .DMCtrl(dmctrl_w[0]), .RUWr(ruwr_w[0]),
      .RUDATAWrSrc(wrsrc_w[0]), .ImmSrc_de(imm_w[0]),
      .DMRd(dmrd_w[0]), .md_op(mdop_w[0]),
      .md_funct(mdf_w[0]), .illegal(ill_w[0]),
      .illegal_count(icnt_w[0])
   );

   decode_ctrl_stage #(
      .XLEN(32), .ENABLE_M(1),
      .MUL_LAT(LAT_MUL), .DIV_LAT(LAT_DIV)
   ) u1 (
      .clk(clk), .rst(rst), .up(if1.slave),
      .stall_ex(stall_ex), .flush(flush),
      .out_valid(ov_w[1]), .out_pc(opc_w[1]),
      .out_instr(oin_w[1]), .ALUASrc(asrc_w[1]),
      .ALUBSrc(bsrc_w[1]), .ALUOp(aluop_w[1]),
      .BrOp(brop_w[1]), .DMWr(dmwr_w[1]),
      .DMCtrl(dmctrl_w[1]), .RUWr(ruwr_w[1]),
      .RUDATAWrSrc(wrsrc_w[1]), .ImmSrc_de(imm_w[1]),
      .DMRd(dmrd_w[1]), .md_op(mdop_w[1]),
      .md_funct(mdf_w[1]), .illegal(ill_w[1]),
      .illegal_count(icnt_w[1])
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input int e,
                      input logic [63:0] a,
                      input logic [63:0] x);
      checks++;
      if (a !== x) begin
         errors++;
         $display("FAIL %s dut%0d: got %0h want %0h",
                  nm, e, a, x);
      end
   endtask

   function automatic ctrl_t act(input int e);
      ctrl_t c;
      c.asrc   = asrc_w[e];
      c.bsrc   = bsrc_w[e];
      c.aluop  = aluop_w[e];
      c.brop   = brop_w[e];
      c.dmwr   = dmwr_w[e];
      c.dmctrl = dmctrl_w[e];
      c.ruwr   = ruwr_w[e];
      c.wrsrc  = wrsrc_w[e];
      c.imm    = imm_w[e];
      c.dmrd   = dmrd_w[e];
      c.mdop   = mdop_w[e];
      c.mdf    = mdf_w[e];
      c.ill    = ill_w[e];
      return c;
   endfunction

   function automatic ctrl_t mk(
      input logic a, input logic [3:0] alu,
      input logic [4:0] br, input logic dw,
      input logic [2:0] dc, input logic rw,
      input logic [1:0] ws, input logic [2:0] im,
      input logic dr, input logic mo,
      input logic [2:0] mf, input logic il);
      ctrl_t c;
      c = '{a, 1'b0, alu, br, dw, dc, rw, ws, im,
            dr, mo, mf, il};
      return c;
   endfunction

   // Reference decode: classify, judge legality, fill fields.
   function automatic ctrl_t ref_dec(input logic [31:0] x,
                                     input bit en_m);
      ctrl_t      c;
      bit         ok;
      logic [2:0] f3;
      logic [6:0] f7;
      c  = '0;
      ok = 1'b1;
      f3 = x[14:12];
      f7 = x[31:25];
      case (x[6:0])
         7'h33: begin
            c.ruwr = 1'b1;
            if (en_m && f7 == 7'h01) begin
               c.mdop  = 1'b1;
               c.mdf   = f3;
               c.wrsrc = 2'd3;
            end else begin
               c.aluop = {f7[5], f3};
               ok = (f7 == 7'h00) ||
                    (f7 == 7'h20 && f3 inside {3'd0, 3'd5});
            end
         end
         7'h13: begin
            c.ruwr = 1'b1;
            if (f3 inside {3'd1, 3'd5}) c.aluop = {f7[5], f3};
            else c.aluop = {1'b0, f3};
            if (f3 == 3'd1 && f7 != 7'h00) ok = 1'b0;
            if (f3 == 3'd5 && !(f7 inside {7'h00, 7'h20}))
               ok = 1'b0;
         end
         7'h03: begin
            c.dmctrl = f3;
            c.dmrd   = 1'b1;
            c.ruwr   = 1'b1;
            c.wrsrc  = 2'd1;
            ok = !(f3 inside {3'd3, 3'd6, 3'd7});
         end
         7'h23: begin
            c.dmwr = 1'b1;
            c.imm  = 3'd1;
            ok = (f3 <= 3'd2);
         end
         7'h63: begin
            c.brop = {2'b01, f3};
            c.imm  = 3'd5;
            ok = !(f3 inside {3'd2, 3'd3});
         end
         7'h67: begin
            c.brop  = 5'h10;
            c.ruwr  = 1'b1;
            c.wrsrc = 2'd2;
            ok = (f3 == 3'd0);
         end
         7'h6F: begin
            c.brop  = 5'h10;
            c.ruwr  = 1'b1;
            c.wrsrc = 2'd2;
            c.imm   = 3'd6;
         end
         7'h37: begin
            c.aluop = 4'd7;
            c.ruwr  = 1'b1;
            c.imm   = 3'd2;
         end
         7'h17: begin
            c.asrc = 1'b1;
            c.ruwr = 1'b1;
            c.imm  = 3'd2;
         end
         default: ok = 1'b0;
      endcase
      if (!ok) begin
         c     = '0;
         c.ill = 1'b1;
      end
      return c;
   endfunction

   // ---------------- model state ----------------
   // free_at: first cycle index at which the stage may accept
   // again after a mul/div issue (busy window as a time span).
   ctrl_t       m_ctrl [2];
   bit          m_val  [2];
   logic [31:0] m_pc   [2];
   logic [31:0] m_ins  [2];
   int          m_icnt [2];
   int          free_at[2];
   int          cyc    = 0;
   bit          mdl_ok = 1'b0;
   ctrl_t       m_d;
   bit          m_rdy;

   initial begin
      for (int e = 0; e < 2; e++) begin
         m_ctrl[e]  = '0;
         m_val[e]   = 1'b0;
         m_pc[e]    = '0;
         m_ins[e]   = '0;
         m_icnt[e]  = 0;
         free_at[e] = 0;
      end
   end

   always @(posedge clk) begin
      for (int e = 0; e < 2; e++) begin
         m_d   = ref_dec(instr, e == 1);
         m_rdy = !rst && !stall_ex && !flush &&
                 (cyc >= free_at[e]);
         if (rst) begin
            m_val[e]   = 1'b0;
            m_ctrl[e]  = '0;
            m_pc[e]    = '0;
            m_ins[e]   = '0;
            m_icnt[e]  = 0;
            free_at[e] = cyc + 1;
         end else if (flush) begin
            m_val[e] = 1'b0;
            if (free_at[e] > cyc + 1) free_at[e] = cyc + 1;
         end else if (stall_ex) begin
            m_val[e] = m_val[e];
         end else if (in_valid && m_rdy) begin
            m_val[e]  = 1'b1;
            m_ctrl[e] = m_d;
            m_pc[e]   = pc;
            m_ins[e]  = instr;
            if (m_d.ill && m_icnt[e] < 65535) m_icnt[e]++;
            if (m_d.mdop)
               free_at[e] = cyc + 1 +
                            (instr[14] ? LAT_DIV : LAT_MUL);
         end else begin
            m_val[e] = 1'b0;
         end
      end
      if (rst) mdl_ok = 1'b1;
      cyc++;
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (mdl_ok) begin
         for (int e = 0; e < 2; e++) begin
            chk("in_ready", e, 64'(ir_w[e]),
                64'(!rst && !stall_ex && !flush &&
                    (cyc >= free_at[e])));
            chk("out_valid", e, 64'(ov_w[e]), 64'(m_val[e]));
            chk("illegal_count", e, 64'(icnt_w[e]),
                64'(m_icnt[e]));
            if (m_val[e]) begin
               chk("ctrl", e, 64'(act(e)), 64'(m_ctrl[e]));
               chk("out_pc", e, 64'(opc_w[e]), 64'(m_pc[e]));
               chk("out_instr", e, 64'(oin_w[e]),
                   64'(m_ins[e]));
            end else begin
               chk("gated", e,
                   64'({ruwr_w[e], dmwr_w[e], dmrd_w[e],
                        mdop_w[e], brop_w[e], ill_w[e]}),
                   64'd0);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] x);
      in_valid = 1'b1;
      instr    = x;
      pc       = pc + 32'd4;
   endtask

   logic [31:0] s_ins [12];
   ctrl_t       s_exp [12];
   logic [31:0] bad   [9];
   int          n;

   initial begin
      #5_000_000;
      $display("FAIL watchdog dut1: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      s_ins[0]  = I_ADD;
      s_exp[0]  = mk(0, 4'h0, 5'h00, 0, 3'd0, 1, 2'd0, 3'd0,
                     0, 0, 3'd0, 0);
      s_ins[1]  = I_LW;
      s_exp[1]  = mk(0, 4'h0, 5'h00, 0, 3'd2, 1, 2'd1, 3'd0,
                     1, 0, 3'd0, 0);
      s_ins[2]  = I_SW;
      s_exp[2]  = mk(0, 4'h0, 5'h00, 1, 3'd0, 0, 2'd0, 3'd1,
                     0, 0, 3'd0, 0);
      s_ins[3]  = 32'h00208063;
      s_exp[3]  = mk(0, 4'h0, 5'h08, 0, 3'd0, 0, 2'd0, 3'd5,
                     0, 0, 3'd0, 0);
      s_ins[4]  = 32'h000000EF;
      s_exp[4]  = mk(0, 4'h0, 5'h10, 0, 3'd0, 1, 2'd2, 3'd6,
                     0, 0, 3'd0, 0);
      s_ins[5]  = 32'h123450B7;
      s_exp[5]  = mk(0, 4'h7, 5'h00, 0, 3'd0, 1, 2'd0, 3'd2,
                     0, 0, 3'd0, 0);
      s_ins[6]  = 32'h00000097;
      s_exp[6]  = mk(1, 4'h0, 5'h00, 0, 3'd0, 1, 2'd0, 3'd2,
                     0, 0, 3'd0, 0);
      s_ins[7]  = 32'h403100B3;
      s_exp[7]  = mk(0, 4'h8, 5'h00, 0, 3'd0, 1, 2'd0, 3'd0,
                     0, 0, 3'd0, 0);
      s_ins[8]  = 32'h40315093;
      s_exp[8]  = mk(0, 4'hD, 5'h00, 0, 3'd0, 1, 2'd0, 3'd0,
                     0, 0, 3'd0, 0);
      s_ins[9]  = 32'h000100E7;
      s_exp[9]  = mk(0, 4'h0, 5'h10, 0, 3'd0, 1, 2'd2, 3'd0,
                     0, 0, 3'd0, 0);
      s_ins[10] = 32'hC0010093;
      s_exp[10] = mk(0, 4'h0, 5'h00, 0, 3'd0, 1, 2'd0, 3'd0,
                     0, 0, 3'd0, 0);
      s_ins[11] = 32'h00015083;
      s_exp[11] = mk(0, 4'h0, 5'h00, 0, 3'd5, 1, 2'd1, 3'd0,
                     1, 0, 3'd0, 0);

      bad[0] = 32'h003100B0;
      bad[1] = 32'h0000007F;
      bad[2] = 32'h02311093;
      bad[3] = 32'h02315093;
      bad[4] = 32'h403110B3;
      bad[5] = 32'h00013083;
      bad[6] = 32'h00113023;
      bad[7] = 32'h0020A063;
      bad[8] = 32'h000010E7;

      // Pin the reference decoder to hand-derived values.
      for (int i = 0; i < 12; i++)
         chk("model_pin", 1, 64'(ref_dec(s_ins[i], 1'b1)),
             64'(s_exp[i]));
      chk("model_mul_m0", 0, 64'(ref_dec(I_MUL, 1'b0)),
          64'(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)));

      rst = 1'b1; in_valid = 1'b0; stall_ex = 1'b0;
      flush = 1'b0; instr = '0; pc = 32'h1000;
      tick();
      tick();
      for (int e = 0; e < 2; e++) begin
         chk("rst_valid", e, 64'(ov_w[e]), 64'd0);
         chk("rst_icnt", e, 64'(icnt_w[e]), 64'd0);
         chk("rst_pc", e, 64'(opc_w[e]), 64'd0);
         chk("rst_ready", e, 64'(ir_w[e]), 64'd0);
      end
      rst = 1'b0;

      // mul: legal on dut1 (busy 3), illegal on dut0.
      send(I_MUL);
      tick();
      chk("mul_ctrl", 1, 64'(act(1)),
          64'(mk(0, 0, 0, 0, 0, 1, 2'd3, 0, 0, 1, 3'd0, 0)));
      chk("mul_ill", 0, 64'({ill_w[0], ruwr_w[0]}), 64'b10);
      chk("mul_icnt", 0, 64'(icnt_w[0]), 64'd1);
      chk("mul_busy", 1, 64'(ir_w[1]), 64'd0);
      chk("mul_nobusy", 0, 64'(ir_w[0]), 64'd1);
      in_valid = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      chk("flush_ready", 1, 64'(ir_w[1]), 64'd1);
      chk("flush_valid", 1, 64'(ov_w[1]), 64'd0);

      // Back-to-back stream, one bundle per cycle.
      for (int i = 0; i < 12; i++) begin
         send(s_ins[i]);
         tick();
         chk("stream_ctrl", 1, 64'(act(1)), 64'(s_exp[i]));
         chk("stream_instr", 0, 64'(oin_w[0]), 64'(s_ins[i]));
      end
      in_valid = 1'b0;
      tick();

      // div then add held valid.
      send(I_DIV);
      tick();
      send(I_ADD);
      n = 1;
      while (n < 30 && !(ov_w[1] && oin_w[1] == I_ADD)) begin
         tick();
         n++;
      end
      chk("div_add_cycle", 1, 64'(n), 64'd10);
      in_valid = 1'b0;
      tick();

      // Reset mid-busy abandons the sequence.
      send(I_DIV);
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rst_busy_ready", 1, 64'(ir_w[1]), 64'd1);

      // Stall freezes; flush during stall kills.
      send(I_LW);
      tick();
      stall_ex = 1'b1;
      send(I_SW);
      for (int i = 0; i < 3; i++) begin
         tick();
         for (int e = 0; e < 2; e++) begin
            chk("stall_instr", e, 64'(oin_w[e]), 64'(I_LW));
            chk("stall_valid", e, 64'(ov_w[e]), 64'd1);
         end
      end
      flush = 1'b1;
      tick();
      for (int e = 0; e < 2; e++)
         chk("stall_flush", e, 64'(ov_w[e]), 64'd0);
      flush = 1'b0;
      stall_ex = 1'b0;
      in_valid = 1'b0;
      tick();

      // Illegal encodings.
      for (int i = 0; i < 9; i++) begin
         send(bad[i]);
         tick();
         for (int e = 0; e < 2; e++)
            chk("illegal", e,
                64'({ill_w[e], ruwr_w[e], dmwr_w[e]}),
                64'b100);
      end

      // Saturate the illegal counter.
      send(32'h0);
      repeat (70000) tick();
      for (int e = 0; e < 2; e++)
         chk("icnt_sat", e, 64'(icnt_w[e]), 64'hFFFF);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      in_valid = 1'b0;
      for (int e = 0; e < 2; e++) begin
         chk("icnt_rst", e, 64'(icnt_w[e]), 64'd0);
         chk("valid_rst", e, 64'(ov_w[e]), 64'd0);
      end
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

endmodule

// File: doc/decode_ctrl_stage.md
DECODE_CTRL_STAGE -- requirements
Module: decode_ctrl_stage

Interface
REQ-001 Param XLEN, 32, width of pc and out_pc.
REQ-002 Param ENABLE_M, 1, 1 = RV32M mul/div decoded; 0 = RV32M encodings illegal.
REQ-003 Param MUL_LAT, 3, busy cycles after a MUL* issue; legal range 1..15.
REQ-004 Param DIV_LAT, 8, busy cycles after a DIV*/REM* issue; legal range 1..15.
REQ-005 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-006 Port clk, in, 1, rising-edge clock.
REQ-007 Port rst, in, 1, synchronous active-high reset.
REQ-008 Ports in_valid (in, 1), in_ready (out, 1), instr (in, 32), pc (in, XLEN): upstream IF/ID handshake.
REQ-009 Ports stall_ex (in, 1) and flush (in, 1): downstream hold and pipeline kill.
REQ-010 Port out_valid, out, 1, ID/EX bundle valid.
REQ-011 Ports out_pc (out, XLEN) and out_instr (out, 32): registered copies of pc and instr.
REQ-012 Control outputs, all out and registered:
- ALUASrc (1), ALUBSrc (1), ALUOp (4), BrOp (5)
- DMWr (1), DMCtrl (3), RUWr (1), RUDATAWrSrc (2)
- ImmSrc_de (3), DMRd (1), md_op (1), md_funct (3)
REQ-013 Port illegal, out, 1, registered instruction is illegal.
REQ-014 Port illegal_count, out, 16, saturating count of accepted illegal instructions.

Function
REQ-015 Decode encodings SHALL be as follows:
- R: ALUOp = {f7[5], f3}.
- I-ALU: ALUOp = {f7[5], f3} for f3 = 001/101, else {0, f3}.
- Load: DMCtrl = f3, DMRd = 1, RUDATAWrSrc = 01.
- JALR and JAL: BrOp = 10000, RUDATAWrSrc = 10.
- Store: DMWr = 1, ImmSrc_de = 001.
- Branch: BrOp = {01, f3}, ImmSrc_de = 101.
- JAL: ImmSrc_de = 110.
- LUI: ALUOp = 0111, ImmSrc_de = 010.
- AUIPC: ALUASrc = 1, ImmSrc_de = 010.
REQ-016 RUWr SHALL be 1 for R, I-ALU, load, JALR, JAL, LUI, AUIPC and M ops, and 0 otherwise.
REQ-017 An M op (opcode 0110011, f7 = 0000001, ENABLE_M = 1) SHALL decode as md_op = 1, md_funct = f3, RUWr = 1, RUDATAWrSrc = 11, ALUOp = 0000.
REQ-018 The instruction SHALL be illegal if any of the following holds:
- instr[1:0] != 11, or unknown opcode;
- R f7 not in {0000000, 0100000 with f3 in {000, 101}, 0000001 with ENABLE_M};
- SLLI with f7 != 0; SRLI/SRAI with f7 not in {0000000, 0100000};
- load f3 in {011, 110, 111}; store f3 > 010; branch f3 in {010, 011}; JALR f3 != 000.
REQ-019 For an illegal instruction: illegal = 1; RUWr, DMWr, DMRd, md_op = 0; BrOp = 0; all other controls = 0.
REQ-020 in_ready SHALL be !stall_ex && state == IDLE && !flush.
REQ-021 Transfer occurs when in_valid && in_ready.
REQ-022 Latency: a transferred instruction SHALL appear on the outputs exactly 1 cycle later.
REQ-023 Output register priority SHALL be:
1. flush: out_valid <= 0.
2. stall_ex: hold all outputs.
3. Transfer: load the decoded bundle, out_valid <= 1.
4. Otherwise: out_valid <= 0.
REQ-024 Whenever out_valid = 0, RUWr, DMWr, DMRd, md_op, BrOp and illegal SHALL read 0.
REQ-025 FSM states SHALL be IDLE and MD_BUSY, with a 4-bit counter cnt.
REQ-026 IDLE -> MD_BUSY SHALL occur on transfer of a legal M op, with cnt <= (f3[2] ? DIV_LAT : MUL_LAT) - 1.
REQ-027 In MD_BUSY with cnt != 0: cnt decrements each cycle, independent of stall_ex.
REQ-028 MD_BUSY -> IDLE SHALL occur when cnt == 0 at a clock edge.
REQ-029 flush in MD_BUSY SHALL force IDLE and cnt = 0 on the next edge.
REQ-030 With LAT = 1, the FSM SHALL spend exactly 1 cycle in MD_BUSY; in general in_ready is low for exactly LAT cycles after the issue edge.
REQ-031 illegal_count SHALL increment on each transfer of an illegal instruction not coincident with flush, and saturate at 0xFFFF.
REQ-032 flush and stall_ex asserted together: flush wins.
REQ-033 in_valid with stall_ex = 1: no transfer; instr and pc are not sampled.

Reset
REQ-034 While rst = 1 at a clock edge, the next state SHALL be:
- state = IDLE, cnt = 0
- out_valid = 0, illegal = 0, illegal_count = 0
- all control outputs = 0, out_pc = 0, out_instr = 0
REQ-035 rst SHALL take priority over flush, stall_ex and transfer.
REQ-036 in_ready SHALL be 0 during reset cycles.
REQ-037 rst mid-MD_BUSY SHALL abandon the sequence.

Verification
REQ-038 Stream add, lw, sw, beq, jal, lui, auipc with stall_ex = 0 -> one bundle per cycle, 1-cycle latency, fields per REQ-015/016, LUI RUWr = 1.
REQ-039 ENABLE_M = 1, DIV_LAT = 8: issue div, then add held valid -> in_ready low 8 cycles, add appears at cycle 10, out_valid = 0 between.
REQ-040 ENABLE_M = 0: issue mul (f7 = 0000001) -> illegal = 1, RUWr = 0, illegal_count = 1, no MD_BUSY.
REQ-041 Issue mul (MUL_LAT = 3), flush at busy cycle 1 -> in_ready high next cycle, out_valid = 0.
REQ-042 stall_ex high 3 cycles with valid bundle -> outputs frozen; flush during stall -> out_valid = 0 next edge.
REQ-043 Inject 0x0000_0000 70000 times -> illegal_count saturates at 0xFFFF; rst -> illegal_count = 0, out_valid = 0.
